// File: rtl/matrix_result_drain.sv
// matrix_result_drain
// Buffers completed result rows from the matrix multiply engine in a small row FIFO and
// serializes them element by element onto a valid/ready stream.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   row_write      a result row is present this cycle
//   row_addr       row index from the engine
//   row_data       row elements (unpacked, SIZE_COUNT words)
//   row_last_col   index of the last element to emit for this row
//   row_full       FIFO holds DEPTH rows
//   overflow       sticky: a row arrived while full and was dropped
//   out_valid      stream element valid
//   out_ready      sink accepts the current element
//   out_data       element value
//   out_row        row address of the element
//   out_col        column index of the element
//   out_last       element is the last of its row
//   busy           FIFO non-empty
module matrix_result_drain #(
   parameter int unsigned SIZE_COUNT = 8,
   parameter int unsigned SIZE_WIDTH = $clog2(SIZE_COUNT),
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  row_write,
   input  logic [ADDR_WIDTH-1:0] row_addr,
   input  logic [DATA_WIDTH-1:0] row_data [SIZE_COUNT],
   input  logic [SIZE_WIDTH-1:0] row_last_col,
   output logic                  row_full,
   output logic                  overflow,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0] out_row,
   output logic [SIZE_WIDTH-1:0] out_col,
   output logic                  out_last,
   output logic                  busy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

   // Entry storage; not reset, validity is tracked by count alone.
   logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem [DEPTH][SIZE_COUNT];
   logic [SIZE_WIDTH-1:0] last_mem [DEPTH];

   logic [PTR_W:0]        count;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [SIZE_WIDTH-1:0] col_idx;
   logic                  overflow_q;

   logic full;
   logic push;
   logic fire;
   logic pop;

   // Fullness uses the pre-edge count, so a same-cycle pop never frees a slot for a push.
   assign full = (count == FULL_COUNT);
   assign push = row_write && !full;
   assign fire = out_valid && out_ready;
   assign pop  = fire && out_last;

   // Outputs depend only on registered state.
   assign out_valid = (count != '0);
   assign busy      = out_valid;
   assign row_full  = full;
   assign overflow  = overflow_q;
   assign out_data  = data_mem[rd_ptr][col_idx];
   assign out_row   = addr_mem[rd_ptr];
   assign out_col   = col_idx;
   // Gated by out_valid so stale storage cannot raise out_last while empty.
   assign out_last  = out_valid && (col_idx == last_mem[rd_ptr]);

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr] <= row_addr;
         data_mem[wr_ptr] <= row_data;
         last_mem[wr_ptr] <= row_last_col;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count      <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         col_idx    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (row_write && full) begin
            overflow_q <= 1'b1;
         end
         if (pop) begin
            rd_ptr  <= rd_ptr + PTR_W'(1);
            col_idx <= '0;
         end else if (fire) begin
            col_idx <= col_idx + SIZE_WIDTH'(1);
         end
         if (push && !pop) begin
            count <= count + (PTR_W + 1)'(1);
         end else if (pop && !push) begin
            count <= count - (PTR_W + 1)'(1);
         end
      end
   end

endmodule

// File: tb/tb_matrix_result_drain.sv
module tb_matrix_result_drain;

   localparam int unsigned SIZE_COUNT = 8;
   localparam int unsigned SIZE_WIDTH = 3;
   localparam int unsigned ADDR_WIDTH = 32;
   localparam int unsigned DATA_WIDTH = 16;
   localparam int unsigned DEPTH      = 4;

   logic                  clk;
   logic                  reset;
   logic                  row_write;
   logic [ADDR_WIDTH-1:0] row_addr;
   logic [DATA_WIDTH-1:0] row_data [SIZE_COUNT];
   logic [SIZE_WIDTH-1:0] row_last_col;
   logic                  row_full;
   logic                  overflow;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [ADDR_WIDTH-1:0] out_row;
   logic [SIZE_WIDTH-1:0] out_col;
   logic                  out_last;
   logic                  busy;

   int total;
   int bad;

   matrix_result_drain #(
      .SIZE_COUNT(SIZE_COUNT),
      .SIZE_WIDTH(SIZE_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .row_write   (row_write),
      .row_addr    (row_addr),
      .row_data    (row_data),
      .row_last_col(row_last_col),
      .row_full    (row_full),
      .overflow    (overflow),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_row     (out_row),
      .out_col     (out_col),
      .out_last    (out_last),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs and row payload: element i of a row carries base*(i+1).
   typedef struct {
      logic        wr;
      int unsigned addr;
      int unsigned base;
      int unsigned lc;
      logic        rdy;
      logic        v;
      int unsigned data;
      int unsigned row;
      int unsigned col;
      logic        last;
      logic        bsy;
      logic        full;
   } vec_t;

   vec_t vecs [28];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic set_row(input logic wr, input int unsigned addr, input int unsigned base,
                          input int unsigned lc);
      row_write    = wr;
      row_addr     = addr;
      row_last_col = SIZE_WIDTH'(lc);
      for (int i = 0; i < SIZE_COUNT; i++) row_data[i] = DATA_WIDTH'(base * (i + 1));
   endtask

   function automatic vec_t mk(logic wr, int unsigned addr, int unsigned base, int unsigned lc,
                               logic rdy, logic v, int unsigned data, int unsigned row,
                               int unsigned col, logic last, logic bsy, logic full);
      vec_t t;
      t.wr = wr; t.addr = addr; t.base = base; t.lc = lc; t.rdy = rdy;
      t.v = v; t.data = data; t.row = row; t.col = col; t.last = last;
      t.bsy = bsy; t.full = full;
      return t;
   endfunction

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      out_ready = 1'b0;
      set_row(1'b0, 0, 0, 0);

      // Outputs reflect state before the upcoming edge; a row pushed in vector k shows in k+1.
      // Single row, addr 3, data 10/20/30, last_col 2.
      vecs[0]  = mk(1, 3, 10, 2, 1,  0,   0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(0, 0,  0, 0, 1,  1,  10, 3, 0, 0, 1, 0);
      vecs[2]  = mk(0, 0,  0, 0, 1,  1,  20, 3, 1, 0, 1, 0);
      vecs[3]  = mk(0, 0,  0, 0, 1,  1,  30, 3, 2, 1, 1, 0);
      vecs[4]  = mk(0, 0,  0, 0, 1,  0,   0, 0, 0, 0, 0, 0);
      // Backpressure: ready low for 5 cycles after valid rises.
      vecs[5]  = mk(1, 3, 10, 2, 0,  0,   0, 0, 0, 0, 0, 0);
      vecs[6]  = mk(0, 0,  0, 0, 0,  1,  10, 3, 0, 0, 1, 0);
      vecs[7]  = mk(0, 0,  0, 0, 0,  1,  10, 3, 0, 0, 1, 0);
      vecs[8]  = mk(0, 0,  0, 0, 0,  1,  10, 3, 0, 0, 1, 0);
      vecs[9]  = mk(0, 0,  0, 0, 0,  1,  10, 3, 0, 0, 1, 0);
      vecs[10] = mk(0, 0,  0, 0, 0,  1,  10, 3, 0, 0, 1, 0);
      vecs[11] = mk(0, 0,  0, 0, 1,  1,  10, 3, 0, 0, 1, 0);
      vecs[12] = mk(0, 0,  0, 0, 1,  1,  20, 3, 1, 0, 1, 0);
      vecs[13] = mk(0, 0,  0, 0, 1,  1,  30, 3, 2, 1, 1, 0);
      vecs[14] = mk(0, 0,  0, 0, 1,  0,   0, 0, 0, 0, 0, 0);
      // Push/pop together at count 2, then fill to prove count stayed at 2.
      vecs[15] = mk(1, 5, 50, 1, 0,  0,   0, 0, 0, 0, 0, 0);
      vecs[16] = mk(1, 6, 60, 0, 1,  1,  50, 5, 0, 0, 1, 0);
      vecs[17] = mk(1, 7, 70, 1, 1,  1, 100, 5, 1, 1, 1, 0);
      vecs[18] = mk(0, 0,  0, 0, 0,  1,  60, 6, 0, 1, 1, 0);
      vecs[19] = mk(1, 8, 80, 0, 0,  1,  60, 6, 0, 1, 1, 0);
      vecs[20] = mk(1, 9, 90, 0, 0,  1,  60, 6, 0, 1, 1, 0);
      vecs[21] = mk(0, 0,  0, 0, 0,  1,  60, 6, 0, 1, 1, 1);
      vecs[22] = mk(0, 0,  0, 0, 1,  1,  60, 6, 0, 1, 1, 1);
      vecs[23] = mk(0, 0,  0, 0, 1,  1,  70, 7, 0, 0, 1, 0);
      vecs[24] = mk(0, 0,  0, 0, 1,  1, 140, 7, 1, 1, 1, 0);
      // Two single-element rows back to back.
      vecs[25] = mk(0, 0,  0, 0, 1,  1,  80, 8, 0, 1, 1, 0);
      vecs[26] = mk(0, 0,  0, 0, 1,  1,  90, 9, 0, 1, 1, 0);
      vecs[27] = mk(0, 0,  0, 0, 1,  0,   0, 0, 0, 0, 0, 0);

      step();
      step();
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_last", 32'(out_last), 0);
      chk("rst_full", 32'(row_full), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ovf", 32'(overflow), 0);
      reset = 1'b0;

      for (int k = 0; k < 28; k++) begin
         set_row(vecs[k].wr, vecs[k].addr, vecs[k].base, vecs[k].lc);
         out_ready = vecs[k].rdy;
         #1;
         chk($sformatf("v%0d_valid", k), 32'(out_valid), 32'(vecs[k].v));
         chk($sformatf("v%0d_last", k), 32'(out_last), 32'(vecs[k].last));
         chk($sformatf("v%0d_busy", k), 32'(busy), 32'(vecs[k].bsy));
         chk($sformatf("v%0d_full", k), 32'(row_full), 32'(vecs[k].full));
         chk($sformatf("v%0d_ovf", k), 32'(overflow), 0);
         if (vecs[k].v) begin
            chk($sformatf("v%0d_data", k), 32'(out_data), vecs[k].data);
            chk($sformatf("v%0d_row", k), out_row, vecs[k].row);
            chk($sformatf("v%0d_col", k), 32'(out_col), vecs[k].col);
         end
         step();
      end

      // Overflow: five writes into a four-deep FIFO with the sink stalled.
      out_ready = 1'b0;
      for (int r = 0; r < 5; r++) begin
         set_row(1'b1, r, r + 1, 1);
         #1;
         if (r == 3) chk("ovf_notfull3", 32'(row_full), 0);
         if (r == 4) begin
            chk("ovf_full4", 32'(row_full), 1);
            chk("ovf_pre", 32'(overflow), 0);
         end
         step();
      end
      set_row(1'b0, 0, 0, 0);
      #1;
      chk("ovf_set", 32'(overflow), 1);
      chk("ovf_full", 32'(row_full), 1);
      out_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("drain%0d_%0d_valid", r, c), 32'(out_valid), 1);
            chk($sformatf("drain%0d_%0d_row", r, c), out_row, r);
            chk($sformatf("drain%0d_%0d_col", r, c), 32'(out_col), c);
            chk($sformatf("drain%0d_%0d_data", r, c), 32'(out_data), (r + 1) * (c + 1));
            chk($sformatf("drain%0d_%0d_last", r, c), 32'(out_last), (c == 1) ? 1 : 0);
            step();
         end
      end
      chk("drain_empty", 32'(out_valid), 0);
      chk("drain_busy", 32'(busy), 0);
      chk("ovf_sticky", 32'(overflow), 1);

      // Reset mid-stream with a three-row backlog.
      out_ready = 1'b0;
      for (int r = 0; r < 3; r++) begin
         set_row(1'b1, 20 + r, 1, 2);
         step();
      end
      set_row(1'b0, 0, 0, 0);
      out_ready = 1'b1;
      #1;
      chk("mid_col0", 32'(out_col), 0);
      step();
      chk("mid_col1", 32'(out_col), 1);
      chk("mid_data1", 32'(out_data), 2);
      reset = 1'b1;
      step();
      chk("mrst_valid", 32'(out_valid), 0);
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_ovf", 32'(overflow), 0);
      chk("mrst_last", 32'(out_last), 0);
      reset = 1'b0;
      set_row(1'b1, 11, 5, 1);
      step();
      set_row(1'b0, 0, 0, 0);
      #1;
      chk("post_valid", 32'(out_valid), 1);
      chk("post_row", out_row, 11);
      chk("post_col", 32'(out_col), 0);
      chk("post_data", 32'(out_data), 5);
      step();
      chk("post_col1", 32'(out_col), 1);
      chk("post_data1", 32'(out_data), 10);
      chk("post_last", 32'(out_last), 1);
      step();
      chk("post_empty", 32'(out_valid), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
